// File: rtl/reg_bank_if.sv
// CPU-side bus of reg_bank: addressed, byte-strobed writes and a registered read
// response carrying valid and error strobes.
interface reg_bank_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int REG_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0]  cpu_addr_i;
    logic                   cpu_wr_en_i;
    logic [REG_WIDTH/8-1:0] cpu_be_i;
    logic [REG_WIDTH-1:0]   cpu_wdata_i;
    logic                   cpu_rd_en_i;
    logic [REG_WIDTH-1:0]   cpu_rdata_o;
    logic                   cpu_rvalid_o;
    logic                   cpu_err_o;

    modport master (
        output cpu_addr_i, cpu_wr_en_i, cpu_be_i, cpu_wdata_i, cpu_rd_en_i,
        input  cpu_rdata_o, cpu_rvalid_o, cpu_err_o
    );

    modport slave (
        input  cpu_addr_i, cpu_wr_en_i, cpu_be_i, cpu_wdata_i, cpu_rd_en_i,
        output cpu_rdata_o, cpu_rvalid_o, cpu_err_o
    );
endinterface

// File: rtl/reg_bank.sv
// Parametrised UART control/status register bank with per-bit RW / W1C / read-clear
// CPU policies. Defining REG_BANK_IRQ_EN adds IRQ_MASK and a registered irq_o.
module reg_bank #(
    parameter int                                NUM_REGS    = 4,
    parameter int                                REG_WIDTH   = 32,
    parameter int                                ADDR_WIDTH  = 2,
    parameter logic [NUM_REGS*REG_WIDTH-1:0]     RW_MASK     = '0,
    parameter logic [NUM_REGS*REG_WIDTH-1:0]     W1C_MASK    = '0,
    parameter logic [NUM_REGS*REG_WIDTH-1:0]     RC_MASK     = '0,
    parameter logic [NUM_REGS*REG_WIDTH-1:0]     RESET_VALUE = '0
`ifdef REG_BANK_IRQ_EN
    , parameter logic [NUM_REGS*REG_WIDTH-1:0]   IRQ_MASK    = '0
`endif
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    reg_bank_if.slave                     cpu,
    input  logic [NUM_REGS-1:0]           periph_wr_en_i,
    input  logic [NUM_REGS*REG_WIDTH-1:0] periph_wdata_i,
    input  logic [NUM_REGS*REG_WIDTH-1:0] periph_set_i,
    output logic [NUM_REGS*REG_WIDTH-1:0] data_o,
    output logic [NUM_REGS-1:0]           updated_o
`ifdef REG_BANK_IRQ_EN
    , output logic                        irq_o
`endif
);
    localparam int                  DW         = NUM_REGS * REG_WIDTH;
    localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

    logic [DW-1:0]        r_data;
    logic [DW-1:0]        w_next;
    logic [REG_WIDTH-1:0] r_rdata;
    logic [REG_WIDTH-1:0] w_rd_word;
    logic [REG_WIDTH-1:0] w_be_bits;
    logic                 r_rvalid;
    logic                 r_err;
    logic [NUM_REGS-1:0]  r_updated;
    logic [NUM_REGS-1:0]  w_touch;
    logic                 w_addr_ok;

    assign w_addr_ok = {1'b0, cpu.cpu_addr_i} < NUM_REGS_W;

    always_comb begin
        for (int b = 0; b < REG_WIDTH; b++) begin
            w_be_bits[b] = cpu.cpu_be_i[b/8];
        end
    end

    // Priority is applied lowest-first so each later step overrides the earlier ones:
    // read-clear, then peripheral write, then CPU write, then sticky set.
    always_comb begin
        // NOTE: every combinational output gets a default before the loop; a path that
        // leaves one unassigned would otherwise infer a latch.
        w_next    = r_data;
        w_touch   = '0;
        w_rd_word = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            logic [REG_WIDTH-1:0] cur;
            logic [REG_WIDTH-1:0] rw;
            logic [REG_WIDTH-1:0] set;
            logic [REG_WIDTH-1:0] cpu_chg;
            logic [REG_WIDTH-1:0] word;
            logic                 hit;
            logic                 wr;
            cur     = r_data[r*REG_WIDTH +: REG_WIDTH];
            rw      = RW_MASK[r*REG_WIDTH +: REG_WIDTH];
            set     = periph_set_i[r*REG_WIDTH +: REG_WIDTH];
            hit     = w_addr_ok && (cpu.cpu_addr_i == ADDR_WIDTH'(r));
            wr      = hit && cpu.cpu_wr_en_i;
            cpu_chg = wr ? (w_be_bits & (rw | (W1C_MASK[r*REG_WIDTH +: REG_WIDTH]
                                              & cpu.cpu_wdata_i)))
                         : '0;
            word    = cur;
            if (hit && cpu.cpu_rd_en_i) begin
                word      = word & ~RC_MASK[r*REG_WIDTH +: REG_WIDTH];
                w_rd_word = cur;
            end
            if (periph_wr_en_i[r]) begin
                word = periph_wdata_i[r*REG_WIDTH +: REG_WIDTH];
            end
            word = (word & ~cpu_chg) | (cpu.cpu_wdata_i & rw & cpu_chg);
            word = word | set;
            w_next[r*REG_WIDTH +: REG_WIDTH] = word;
            w_touch[r] = wr | periph_wr_en_i[r] | (|set);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples the
    // pre-edge values; the register contents are architectural, so all of them reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data    <= RESET_VALUE;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
            r_updated <= '0;
        end else begin
            r_data    <= w_next;
            r_updated <= w_touch;
            r_rvalid  <= cpu.cpu_rd_en_i;
            r_err     <= (cpu.cpu_rd_en_i | cpu.cpu_wr_en_i) & ~w_addr_ok;
            if (cpu.cpu_rd_en_i) begin
                r_rdata <= w_rd_word;
            end
        end
    end

`ifdef REG_BANK_IRQ_EN
    logic r_irq;

    // Evaluated on next-state data so irq_o rises together with the bit on data_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(w_next & IRQ_MASK);
        end
    end

    assign irq_o = r_irq;
`endif

    assign data_o           = r_data;
    assign updated_o        = r_updated;
    assign cpu.cpu_rdata_o  = r_rdata;
    assign cpu.cpu_rvalid_o = r_rvalid;
    assign cpu.cpu_err_o    = r_err;
endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed vector table, hand-written corner sequences
// and a randomized run against a bit-level model of the access policies.
module tb_reg_bank;
    localparam int NR = 4;
    localparam int RW = 32;
    localparam int AW = 2;

    localparam logic [127:0] RW_M  = {32'hFFFF_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [127:0] W1C_M = {32'h0, 32'hFFFF_FFFF, 64'h0};
    localparam logic [127:0] RC_M  = {32'h0000_00FF, 96'h0};
    localparam logic [127:0] RST_V = {64'h0, 32'h0000_00A5, 32'h0};
`ifdef REG_BANK_IRQ_EN
    localparam logic [127:0] IRQ_M = {32'h0, 32'h0000_0008, 64'h0};
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_bank_if #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) bus ();
    reg_bank_if #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) bus_b ();

    logic [NR-1:0]    pwr;
    logic [NR*RW-1:0] pwd;
    logic [NR*RW-1:0] pset;
    logic [NR*RW-1:0] data;
    logic [NR-1:0]    upd;
    logic [3*RW-1:0]  data_b;
    logic [2:0]       upd_b;
`ifdef REG_BANK_IRQ_EN
    logic             irq;
`endif

    reg_bank #(
        .NUM_REGS(NR), .REG_WIDTH(RW), .ADDR_WIDTH(AW),
        .RW_MASK(RW_M), .W1C_MASK(W1C_M), .RC_MASK(RC_M), .RESET_VALUE(RST_V)
`ifdef REG_BANK_IRQ_EN
        , .IRQ_MASK(IRQ_M)
`endif
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .cpu(bus),
        .periph_wr_en_i(pwr), .periph_wdata_i(pwd), .periph_set_i(pset),
        .data_o(data), .updated_o(upd)
`ifdef REG_BANK_IRQ_EN
        , .irq_o(irq)
`endif
    );

    reg_bank #(
        .NUM_REGS(3), .REG_WIDTH(RW), .ADDR_WIDTH(AW),
        .RW_MASK({96{1'b1}}), .W1C_MASK('0), .RC_MASK('0), .RESET_VALUE('0)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .cpu(bus_b),
        .periph_wr_en_i(3'b000), .periph_wdata_i(96'h0), .periph_set_i(96'h0),
        .data_o(data_b), .updated_o(upd_b)
`ifdef REG_BANK_IRQ_EN
        , .irq_o()
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.cpu_wr_en_i   = 1'b0;
        bus.cpu_rd_en_i   = 1'b0;
        bus.cpu_addr_i    = '0;
        bus.cpu_be_i      = '0;
        bus.cpu_wdata_i   = '0;
        bus_b.cpu_wr_en_i = 1'b0;
        bus_b.cpu_rd_en_i = 1'b0;
        bus_b.cpu_addr_i  = '0;
        bus_b.cpu_be_i    = '0;
        bus_b.cpu_wdata_i = '0;
        pwr  = '0;
        pwd  = '0;
        pset = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          preg;
        logic        pwr;
        logic [31:0] pwd;
        logic [31:0] pset;
        int          xreg;
        logic [31:0] xval;
        logic [3:0]  xupd;
        logic        xrv;
        logic [31:0] xrd;
    } vec_t;

    vec_t        tbl[13];
    logic [31:0] m_reg[NR];
    logic [31:0] m_nxt[NR];
    logic [31:0] last_rd;

    initial begin
        //          wr rd ad be      wdata          pr pw pwd    pset   xr xval           xupd     rv rdata
        tbl[0]  = '{1, 0, 0, 4'h5, 32'hDEAD_BEEF, 0, 0, 32'h0,  32'h0, 0, 32'h00AD_00EF, 4'b0001, 0, 32'h0};
        tbl[1]  = '{0, 1, 0, 4'h0, 32'h0,         0, 0, 32'h0,  32'h0, 0, 32'h00AD_00EF, 4'b0000, 1, 32'h00AD_00EF};
        tbl[2]  = '{0, 0, 0, 4'h0, 32'h0,         2, 0, 32'h0,  32'h9, 2, 32'h9,         4'b0100, 0, 32'h0};
        tbl[3]  = '{1, 0, 2, 4'hF, 32'h1,         2, 0, 32'h0,  32'h1, 2, 32'h9,         4'b0100, 0, 32'h0};
        tbl[4]  = '{1, 0, 2, 4'hF, 32'h8,         2, 0, 32'h0,  32'h0, 2, 32'h1,         4'b0100, 0, 32'h0};
        tbl[5]  = '{0, 0, 0, 4'h0, 32'h0,         3, 1, 32'h5A, 32'h0, 3, 32'h5A,        4'b1000, 0, 32'h0};
        tbl[6]  = '{0, 1, 3, 4'h0, 32'h0,         3, 0, 32'h0,  32'h0, 3, 32'h0,         4'b0000, 1, 32'h5A};
        tbl[7]  = '{0, 1, 3, 4'h0, 32'h0,         3, 0, 32'h0,  32'h2, 3, 32'h2,         4'b1000, 1, 32'h0};
        tbl[8]  = '{1, 0, 1, 4'hF, 32'h11,        1, 1, 32'h22, 32'h0, 1, 32'h11,        4'b0010, 0, 32'h0};
        tbl[9]  = '{1, 1, 0, 4'hF, 32'h1234_5678, 0, 0, 32'h0,  32'h0, 0, 32'h1234_5678, 4'b0001, 1, 32'h00AD_00EF};
        tbl[10] = '{0, 1, 3, 4'h0, 32'h0,         3, 1, 32'h77, 32'h0, 3, 32'h77,        4'b1000, 1, 32'h2};
        tbl[11] = '{1, 1, 3, 4'hC, 32'hAAAA_5555, 0, 0, 32'h0,  32'h0, 3, 32'hAAAA_0000, 4'b1000, 1, 32'h77};
        tbl[12] = '{1, 0, 0, 4'h0, 32'hFFFF_FFFF, 0, 0, 32'h0,  32'h0, 0, 32'h1234_5678, 4'b0001, 0, 32'h0};

        // Reset values, released away from a clock edge.
        idle();
        rst_n = 1'b0;
        #12;
        for (int r = 0; r < NR; r++) begin
            check($sformatf("reset_data%0d", r), data[r*RW +: RW], RST_V[r*RW +: RW]);
        end
        check("reset_rdata", bus.cpu_rdata_o, 32'h0);
        check("reset_rvalid", bus.cpu_rvalid_o, 32'h0);
        check("reset_err", bus.cpu_err_o, 32'h0);
        check("reset_upd", upd, 32'h0);
        rst_n = 1'b1;

        // Directed vectors, one cycle each.
        last_rd = '0;
        foreach (tbl[i]) begin
            idle();
            bus.cpu_wr_en_i = tbl[i].wr;
            bus.cpu_rd_en_i = tbl[i].rd;
            bus.cpu_addr_i  = tbl[i].addr;
            bus.cpu_be_i    = tbl[i].be;
            bus.cpu_wdata_i = tbl[i].wdata;
            pwr[tbl[i].preg]              = tbl[i].pwr;
            pwd[tbl[i].preg*RW +: RW]     = tbl[i].pwd;
            pset[tbl[i].preg*RW +: RW]    = tbl[i].pset;
            tick();
            check($sformatf("vec%0d_data", i), data[tbl[i].xreg*RW +: RW], tbl[i].xval);
            check($sformatf("vec%0d_upd", i), upd, tbl[i].xupd);
            check($sformatf("vec%0d_rvalid", i), bus.cpu_rvalid_o, tbl[i].xrv);
            check($sformatf("vec%0d_err", i), bus.cpu_err_o, 32'h0);
            if (tbl[i].xrv) last_rd = tbl[i].xrd;
            check($sformatf("vec%0d_rdata", i), bus.cpu_rdata_o, last_rd);
        end

        // Out-of-range accesses on the three-register instance.
        idle();
        bus_b.cpu_wr_en_i = 1'b1;
        bus_b.cpu_addr_i  = 2'd3;
        bus_b.cpu_be_i    = 4'hF;
        bus_b.cpu_wdata_i = 32'hFFFF_FFFF;
        tick();
        check("oor_wr_err", bus_b.cpu_err_o, 32'h1);
        check("oor_wr_rvalid", bus_b.cpu_rvalid_o, 32'h0);
        check("oor_wr_upd", upd_b, 32'h0);
        check("oor_wr_data", (data_b[31:0] | data_b[63:32] | data_b[95:64]), 32'h0);
        idle();
        bus_b.cpu_wr_en_i = 1'b1;
        bus_b.cpu_addr_i  = 2'd2;
        bus_b.cpu_be_i    = 4'hF;
        bus_b.cpu_wdata_i = 32'h0000_0C0C;
        tick();
        check("inr_wr_err", bus_b.cpu_err_o, 32'h0);
        idle();
        bus_b.cpu_rd_en_i = 1'b1;
        bus_b.cpu_addr_i  = 2'd2;
        tick();
        check("inr_rd_rdata", bus_b.cpu_rdata_o, 32'h0000_0C0C);
        idle();
        bus_b.cpu_rd_en_i = 1'b1;
        bus_b.cpu_addr_i  = 2'd3;
        tick();
        check("oor_rd_err", bus_b.cpu_err_o, 32'h1);
        check("oor_rd_rvalid", bus_b.cpu_rvalid_o, 32'h1);
        check("oor_rd_rdata", bus_b.cpu_rdata_o, 32'h0);
        idle();
        tick();
        check("oor_err_pulse", bus_b.cpu_err_o, 32'h0);

        // Asynchronous reset in the middle of a read burst.
        bus.cpu_rd_en_i = 1'b1;
        bus.cpu_addr_i  = 2'd0;
        tick();
        check("pre_rst_rvalid", bus.cpu_rvalid_o, 32'h1);
        check("pre_rst_rdata", bus.cpu_rdata_o, 32'h1234_5678);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_data0", data[31:0], 32'h0);
        check("async_rst_data1", data[63:32], 32'h0000_00A5);
        check("async_rst_rvalid", bus.cpu_rvalid_o, 32'h0);
        check("async_rst_rdata", bus.cpu_rdata_o, 32'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        tick();
        check("post_rst_rvalid", bus.cpu_rvalid_o, 32'h0);

`ifdef REG_BANK_IRQ_EN
        check("irq_reset", irq, 32'h0);
        pset[2*RW +: RW] = 32'h8;
        tick();
        check("irq_set", irq, 32'h1);
        check("irq_set_data", data[2*RW +: RW], 32'h8);
        idle();
        bus.cpu_wr_en_i = 1'b1;
        bus.cpu_addr_i  = 2'd2;
        bus.cpu_be_i    = 4'hF;
        bus.cpu_wdata_i = 32'h8;
        tick();
        check("irq_clear", irq, 32'h0);
        idle();
`endif

        // Randomized run against a bit-level policy model.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int r = 0; r < NR; r++) m_reg[r] = RST_V[r*RW +: RW];
        for (int n = 0; n < 400; n++) begin
            logic [NR-1:0] x_upd;
            logic [31:0]   x_rd;
            idle();
            bus.cpu_wr_en_i = 1'($urandom_range(0, 1));
            bus.cpu_rd_en_i = 1'($urandom_range(0, 1));
            bus.cpu_addr_i  = 2'($urandom_range(0, 3));
            bus.cpu_be_i    = 4'($urandom);
            bus.cpu_wdata_i = $urandom;
            pwr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            for (int r = 0; r < NR; r++) begin
                pwd[r*RW +: RW]  = $urandom;
                pset[r*RW +: RW] = $urandom & $urandom & $urandom;
            end
            x_rd = 32'h0;
            for (int r = 0; r < NR; r++) begin
                logic cpu_w;
                logic cpu_r;
                cpu_w    = bus.cpu_wr_en_i && (int'(bus.cpu_addr_i) == r);
                cpu_r    = bus.cpu_rd_en_i && (int'(bus.cpu_addr_i) == r);
                x_upd[r] = cpu_w || pwr[r] || (pset[r*RW +: RW] != 0);
                if (cpu_r) x_rd = m_reg[r];
                for (int b = 0; b < RW; b++) begin
                    int  k;
                    logic be_hit;
                    k      = r*RW + b;
                    be_hit = cpu_w && bus.cpu_be_i[b/8];
                    if (pset[k])                                      m_nxt[r][b] = 1'b1;
                    else if (be_hit && RW_M[k])                       m_nxt[r][b] = bus.cpu_wdata_i[b];
                    else if (be_hit && W1C_M[k] && bus.cpu_wdata_i[b]) m_nxt[r][b] = 1'b0;
                    else if (pwr[r])                                  m_nxt[r][b] = pwd[k];
                    else if (cpu_r && RC_M[k])                        m_nxt[r][b] = 1'b0;
                    else                                              m_nxt[r][b] = m_reg[r][b];
                end
            end
            if (bus.cpu_rd_en_i) last_rd = x_rd;
            tick();
            for (int r = 0; r < NR; r++) begin
                m_reg[r] = m_nxt[r];
                check($sformatf("rnd%0d_data%0d", n, r), data[r*RW +: RW], m_reg[r]);
            end
            check($sformatf("rnd%0d_upd", n), upd, x_upd);
            check($sformatf("rnd%0d_rvalid", n), bus.cpu_rvalid_o, bus.cpu_rd_en_i);
            check($sformatf("rnd%0d_rdata", n), bus.cpu_rdata_o, last_rd);
        end

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Parametrised bank of NUM_REGS control/status registers for the FPGA UART, replacing the per-register instances.
- Each register bit gets a CPU access policy (RW, W1C, read-clear or read-only) from parameter masks.
- CPU side: addressed, byte-strobed writes and a registered read path with a valid strobe.
- Peripheral side: whole-register writes and per-bit sticky set pulses per register.

Parameters:
- NUM_REGS, 4, number of registers; 1..2**ADDR_WIDTH.
- REG_WIDTH, 32, register width in bits; multiple of 8.
- ADDR_WIDTH, 2, CPU word-address width.
- RW_MASK, all 0, NUM_REGS*REG_WIDTH bits; 1 = CPU-writable bit; register r occupies slice [r*REG_WIDTH +: REG_WIDTH].
- W1C_MASK, all 0, same layout; 1 = CPU write-one-to-clear bit. Must not overlap RW_MASK.
- RC_MASK, all 0, same layout; 1 = bit clears on CPU read.
- RESET_VALUE, all 0, same layout; value loaded on reset.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- cpu_addr_i  in  ADDR_WIDTH  register index.
- cpu_wr_en_i  in  1  CPU write strobe, one cycle per access.
- cpu_be_i  in  REG_WIDTH/8  byte enables for writes.
- cpu_wdata_i  in  REG_WIDTH  CPU write data.
- cpu_rd_en_i  in  1  CPU read strobe.
- cpu_rdata_o  out  REG_WIDTH  read data; valid while cpu_rvalid_o is high.
- cpu_rvalid_o  out  1  one-cycle pulse, one cycle after cpu_rd_en_i.
- cpu_err_o  out  1  one-cycle pulse, one cycle after any access with cpu_addr_i >= NUM_REGS.
- periph_wr_en_i  in  NUM_REGS  per-register peripheral write strobe.
- periph_wdata_i  in  NUM_REGS*REG_WIDTH  peripheral write data.
- periph_set_i  in  NUM_REGS*REG_WIDTH  per-bit set pulses (status/event bits).
- data_o  out  NUM_REGS*REG_WIDTH  current register contents.
- updated_o  out  NUM_REGS  one-cycle pulse after a register changes by write or set.

Behaviour:
Reset
- When rst_ni is low, asynchronously:
  - data_o = RESET_VALUE;
  - cpu_rdata_o = 0, cpu_rvalid_o = 0, cpu_err_o = 0, updated_o = 0.
- Reset asserted mid-access discards the pending read response; no rvalid follows.

Per bit b of register r, priority from highest to lowest (takes effect next clock):
1. periph_set_i[b] = 1 -> bit = 1. A set beats any simultaneous CPU clear or read-clear, so no event is lost.
2. CPU write to r with byte enable covering b:
   - RW bit -> wdata;
   - W1C bit -> cleared if wdata bit = 1, else held;
   - other bits -> held.
3. periph_wr_en_i[r] -> bit = periph_wdata bit. Applies to all bits regardless of mask. Ignored for any bit already changed by (1) or (2) in that cycle.
4. CPU read of r with RC bit -> bit = 0.
5. Otherwise the bit holds.

CPU reads
- Accepted every cycle; no back-pressure.
- Latency is 1 cycle. cpu_rdata_o returns the contents before any same-cycle update, i.e. the read is ordered before a simultaneous write.
- cpu_rdata_o holds its value until the next read. A read with an error returns 0.

Simultaneous CPU read and write
- Both are performed; the read returns the old value.
- RC clearing is skipped for bits written in that cycle.

Out-of-range address (cpu_addr_i >= NUM_REGS)
- No register changes.
- cpu_err_o pulses. If a read, cpu_rvalid_o also pulses with rdata = 0.

updated_o[r]
- Pulses one cycle after a CPU write, peripheral write or set that targets r, even if the value is unchanged.
- Does not pulse for read-clear.

Optional Feature:
- Macro: REG_BANK_IRQ_EN.
- Defined:
  - Adds parameter IRQ_MASK (NUM_REGS*REG_WIDTH, default all 0) and output port irq_o (1 bit).
  - irq_o is registered: irq_o = |(data & IRQ_MASK), evaluated on the next-state data, so it rises in the same cycle the bit appears on data_o.
  - irq_o resets to 0.
- Undefined: irq_o port and IRQ_MASK parameter are absent; no extra logic.

Test Plan:
1. Reset with RESET_VALUE reg1 = 0x0000_00A5 -> data_o reg1 = 0xA5, all other outputs 0. Then drop rst_ni mid-cycle -> outputs clear immediately, not at the next clock edge.
2. reg0 fully RW: write 0xDEADBEEF with be = 4'b0101 over 0x0 -> reg0 = 0x00AD00EF, updated_o[0] pulses 1 cycle. Read reg0 -> rvalid after 1 cycle, rdata = 0x00AD00EF.
3. reg2 W1C, periph_set bits 0 and 3 -> reg2 = 0x9. CPU writes 0x1 while periph_set bit 0 is high in the same cycle -> reg2 stays 0x9. Next write 0x8 -> reg2 = 0x1.
4. reg3 RC on bits [7:0], value 0x5A: read -> rdata = 0x5A, reg3 = 0. Read again with periph_set bit 1 high that cycle -> rdata = 0, reg3 = 0x2.
5. CPU write reg1 = 0x11 and periph_wr_en[1] with 0x22 in the same cycle, RW mask all 1 -> reg1 = 0x11. Read at addr 3 with NUM_REGS = 3 -> cpu_err_o and rvalid pulse, rdata = 0.
6. With REG_BANK_IRQ_EN, IRQ_MASK = reg2 bit 3: periph_set bit 3 -> irq_o = 1. W1C clear of bit 3 -> irq_o = 0 one cycle later.
